// File: rtl/instr_fetch_buffer.sv
// ============================================================================
// Module   : instr_fetch_buffer
// Purpose  : Single-outstanding instruction fetch with a small FIFO toward decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_buffer #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req,
  output logic [PC_W-3:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_misalign,
  output logic            instr_valid,
  input  logic            instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [CW-1:0]   r_count;
  logic            r_inflight;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [PC_W-1:0] r_tag_pc;
  logic            r_tag_mis;
  logic [31:0]     r_mem_data [DEPTH];
  logic [PC_W-1:0] r_mem_pc   [DEPTH];
  logic            r_mem_mis  [DEPTH];

  logic [CW-1:0]   w_occ;
  logic            w_accept;
  logic            w_bypass;
  logic            w_consume;
  logic            w_push;
  logic            w_pop;

  // An in-flight response counts as a credit so the FIFO can never overflow.
  assign w_occ     = r_count + CW'(r_inflight);
  assign pc_ready  = reset && !flush && (w_occ < c_depth);
  assign w_accept  = pc_valid && pc_ready;
  assign imem_req  = w_accept;
  assign imem_addr = pc_in[PC_W-1:2];

  // With an empty FIFO the arriving response is presented straight from the bus.
  assign w_bypass    = r_inflight && (r_count == '0);
  assign instr_valid = (r_count != '0) || r_inflight;
  assign w_consume   = instr_valid && instr_ready && !flush;
  assign w_push      = r_inflight && !flush && !(w_bypass && instr_ready);
  assign w_pop       = w_consume && !w_bypass;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (flush) begin
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_inflight <= w_accept;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_pc  <= pc_in;
      r_tag_mis <= (pc_in[1:0] != 2'b00);
    end
    if (w_push) begin
      r_mem_data[r_wptr] <= imem_rdata;
      r_mem_pc[r_wptr]   <= r_tag_pc;
      r_mem_mis[r_wptr]  <= r_tag_mis;
    end
  end

  always_comb begin
    instr          = '0;
    instr_pc       = '0;
    instr_misalign = 1'b0;
    if (instr_valid) begin
      if (w_bypass) begin
        instr          = imem_rdata;
        instr_pc       = r_tag_pc;
        instr_misalign = r_tag_mis;
      end else begin
        instr          = r_mem_data[r_rptr];
        instr_pc       = r_mem_pc[r_rptr];
        instr_misalign = r_mem_mis[r_rptr];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
// ============================================================================
// Module   : tb_instr_fetch_buffer
// Purpose  : Directed scoreboard bench for instr_fetch_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_misalign;
  logic        instr_valid;
  logic        instr_ready;

  typedef struct {
    logic [31:0] d;
    logic [9:0]  pc;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  instr_fetch_buffer #(.PC_W(10), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .flush(flush), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_misalign(instr_misalign),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    if (a == 8'h04) return 32'h00500093;
    return {16'hC0DE, 8'h5A, a};
  endfunction

  // Instruction memory: data for the requested word appears one cycle later.
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'h0BAD0BAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [9:0] pc);
    exp_t e;
    e.d   = mem_word(pc[9:2]);
    e.pc  = pc;
    e.mis = (pc[1:0] != 2'b00);
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready && !flush) begin
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_instr: got pc=%0h data=%0h, expected nothing", instr_pc, instr);
      end else begin
        e = q.pop_front();
        if (instr !== e.d || instr_pc !== e.pc || instr_misalign !== e.mis) begin
          n_err++;
          $display("FAIL instr_out: got data=%0h pc=%0h mis=%0b, expected data=%0h pc=%0h mis=%0b",
                   instr, instr_pc, instr_misalign, e.d, e.pc, e.mis);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; pc_valid = 1'b1; pc_in = 10'h3FF; flush = 1'b0; instr_ready = 1'b0;
    #3;
    chk("rst_pc_ready", {31'd0, pc_ready}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", {22'd0, instr_pc}, 32'd0);
    chk("rst_misalign", {31'd0, instr_misalign}, 32'd0);
    @(negedge clk);
    pc_valid = 1'b0;
    #1 reset = 1'b1;
    #1 chk("post_rst_pc_ready", {31'd0, pc_ready}, 32'd1);
    step();

    // Single fetch with minimum latency
    pc_valid = 1'b1; pc_in = 10'h010;
    @(negedge clk);
    chk("single_imem_req", {31'd0, imem_req}, 32'd1);
    chk("single_imem_addr", {24'd0, imem_addr}, 32'h04);
    push_exp(10'h010);
    step();
    pc_valid = 1'b0;
    @(negedge clk);
    chk("single_valid", {31'd0, instr_valid}, 32'd1);
    chk("single_instr", instr, 32'h00500093);
    chk("single_pc", {22'd0, instr_pc}, 32'h010);
    step();
    instr_ready = 1'b1;
    @(negedge clk);
    step();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("single_drained", {31'd0, instr_valid}, 32'd0);
    step();

    // Fill and stall
    pc_valid = 1'b1; pc_in = 10'h000;
    @(negedge clk); chk("fill_rdy0", {31'd0, pc_ready}, 32'd1); push_exp(10'h000);
    step(); pc_in = 10'h004;
    @(negedge clk); chk("fill_rdy1", {31'd0, pc_ready}, 32'd1); push_exp(10'h004);
    step(); pc_in = 10'h008;
    @(negedge clk); chk("fill_full0", {31'd0, pc_ready}, 32'd0);
    step();
    @(negedge clk); chk("fill_full1", {31'd0, pc_ready}, 32'd0);
    chk("fill_head_pc", {22'd0, instr_pc}, 32'h000);
    step(); instr_ready = 1'b1;
    @(negedge clk); chk("fill_full2", {31'd0, pc_ready}, 32'd0);
    step();
    @(negedge clk); chk("fill_reopen", {31'd0, pc_ready}, 32'd1); push_exp(10'h008);
    step(); pc_valid = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk); chk("fill_drained", {31'd0, instr_valid}, 32'd0);
    step();

    // Streaming one instruction per cycle
    for (int i = 0; i < 8; i++) begin
      pc_valid = 1'b1; pc_in = 10'(10'h100 + 4 * i);
      @(negedge clk);
      chk("stream_rdy", {31'd0, pc_ready}, 32'd1);
      push_exp(pc_in);
      step();
    end
    pc_valid = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("stream_drained", {31'd0, instr_valid}, 32'd0);
    chk("stream_queue_empty", q.size(), 32'd0);
    step();

    // Flush with one entry buffered and 0x020 in flight
    instr_ready = 1'b0;
    pc_valid = 1'b1; pc_in = 10'h040;
    @(negedge clk); push_exp(10'h040);
    step(); pc_in = 10'h020;
    @(negedge clk); chk("flush_pre_rdy", {31'd0, pc_ready}, 32'd1); push_exp(10'h020);
    step(); flush = 1'b1; pc_in = 10'h0C4;
    @(negedge clk);
    chk("flush_blocks_ready", {31'd0, pc_ready}, 32'd0);
    chk("flush_blocks_req", {31'd0, imem_req}, 32'd0);
    q.delete();
    step(); flush = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid_low", {31'd0, instr_valid}, 32'd0);
    chk("flush_post_rdy", {31'd0, pc_ready}, 32'd1);
    push_exp(10'h0C4);
    step(); pc_valid = 1'b0;
    @(negedge clk); chk("flush_new_pc", {22'd0, instr_pc}, 32'h0C4);
    step();
    @(negedge clk); chk("flush_drained", {31'd0, instr_valid}, 32'd0);
    step();

    // Misaligned fetch
    pc_valid = 1'b1; pc_in = 10'h00F;
    @(negedge clk); chk("mis_addr", {24'd0, imem_addr}, 32'h03); push_exp(10'h00F);
    step(); pc_valid = 1'b0;
    @(negedge clk);
    chk("mis_flag", {31'd0, instr_misalign}, 32'd1);
    chk("mis_pc", {22'd0, instr_pc}, 32'h00F);
    step();

    // Reset mid-operation: one entry buffered, one in flight
    instr_ready = 1'b0;
    pc_valid = 1'b1; pc_in = 10'h080;
    @(negedge clk); push_exp(10'h080);
    step(); pc_in = 10'h084;
    @(negedge clk); push_exp(10'h084);
    step(); pc_in = 10'h088;
    #2 reset = 1'b0;
    q.delete();
    #1;
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_ready", {31'd0, pc_ready}, 32'd0);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_instr", instr, 32'd0);
    pc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1; instr_ready = 1'b1;
    #1 chk("midrst_post_ready", {31'd0, pc_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_quiet", {31'd0, instr_valid}, 32'd0);
    end
    chk("final_queue_empty", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
